// File: rtl/clk_div_monitor_if.sv
// Signal bundle between the divided-clock source and clk_div_monitor.
// The source side (master) drives div_in. The monitor side (slave) drives the status outputs.
interface clk_div_monitor_if #(
  parameter int CNT_W = 13
) ();
  logic             div_in;
  logic             edge_stb;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             lost;

  modport master (output div_in, input edge_stb, period, period_vld, locked, lost);
  modport slave  (input div_in, output edge_stb, period, period_vld, locked, lost);
endinterface

// File: rtl/clk_div_monitor.sv
// Synchronizes a slow divided clock and measures each of its periods in clk cycles.
// Declares lock after a run of in-tolerance periods and flags loss of the clock on timeout.
module clk_div_monitor #(
  parameter int N        = 512,
  parameter int TOL      = 4,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  clk_div_monitor_if.slave  bus
);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  LO      = (N > TOL) ? CNT_W'(N - TOL) : '0;
  localparam logic [CNT_W-1:0]  HI      = CNT_W'(N + TOL);
  localparam logic [CNT_W-1:0]  TMO     = CNT_W'(2 * N);
  localparam logic [GOOD_W-1:0] LOCK_G  = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, MEAS, LOCKED} state_t;

  logic r_s1, r_s2, r_s3, r_rise;
  logic [CNT_W-1:0]  r_cnt;
  state_t            r_state, w_state_nxt;
  logic [GOOD_W-1:0] r_good, w_good_nxt, w_good_inc;
  logic              r_edge_stb, r_period_vld, r_locked, r_lost;
  logic [CNT_W-1:0]  r_period, w_period_nxt;
  logic              w_stb_nxt, w_vld_nxt, w_lost_nxt, w_ok;

  // Rise is registered once more so all decisions work from a clean one-cycle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= bus.div_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      if (r_rise)                r_cnt <= CNT_W'(1);
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_ok       = (r_cnt >= LO) && (r_cnt <= HI) && (r_cnt != CNT_MAX);
  assign w_good_inc = r_good + GOOD_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good;
    w_stb_nxt    = 1'b0;
    w_vld_nxt    = 1'b0;
    w_period_nxt = r_period;
    w_lost_nxt   = r_lost;
    if (r_rise) begin
      w_stb_nxt  = 1'b1;
      w_lost_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          w_state_nxt = MEAS;
          w_good_nxt  = '0;
        end
        MEAS: begin
          w_period_nxt = r_cnt;
          w_vld_nxt    = 1'b1;
          if (w_ok) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == LOCK_G) w_state_nxt = LOCKED;
          end else begin
            w_good_nxt = '0;
          end
        end
        LOCKED: begin
          w_period_nxt = r_cnt;
          w_vld_nxt    = 1'b1;
          if (!w_ok) begin
            w_state_nxt = MEAS;
            w_good_nxt  = '0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (r_state != IDLE && r_cnt == TMO) begin
      // An edge in the same cycle takes priority, so a period of exactly 2N is measured.
      w_state_nxt = IDLE;
      w_good_nxt  = '0;
      w_lost_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_good       <= '0;
      r_edge_stb   <= 1'b0;
      r_period     <= '0;
      r_period_vld <= 1'b0;
      r_locked     <= 1'b0;
      r_lost       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_good       <= w_good_nxt;
      r_edge_stb   <= w_stb_nxt;
      r_period     <= w_period_nxt;
      r_period_vld <= w_vld_nxt;
      r_locked     <= (w_state_nxt == LOCKED);
      r_lost       <= w_lost_nxt;
    end
  end

  assign bus.edge_stb   = r_edge_stb;
  assign bus.period     = r_period;
  assign bus.period_vld = r_period_vld;
  assign bus.locked     = r_locked;
  assign bus.lost       = r_lost;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: drives div_in one clk cycle at a time and compares every output
// against a reference model built from rise times, with a three-cycle output latency.
module tb_clk_div_monitor;
  localparam int N = 512, TOL = 4, LOCK_CNT = 4, CNT_W = 13;
  localparam int LAT = 3;

  typedef struct packed {
    logic             stb;
    logic             vld;
    logic             locked;
    logic             lost;
    logic [CNT_W-1:0] period;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

  clk_div_monitor #(.N(N), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   k, last_rise, run;
  bit   present, prev;
  exp_t cur;
  exp_t q[$];

  task automatic chk(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d at sample %0d", tag, got, exp, k);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("edge_stb",   CNT_W'(bus.edge_stb),   CNT_W'(e.stb));
    chk("period_vld", CNT_W'(bus.period_vld), CNT_W'(e.vld));
    chk("locked",     CNT_W'(bus.locked),     CNT_W'(e.locked));
    chk("lost",       CNT_W'(bus.lost),       CNT_W'(e.lost));
    chk("period",     bus.period,             e.period);
  endtask

  // Reference: a period is the distance between consecutive sampled rises; lock means the
  // clock is present and the current run of good periods has reached LOCK_CNT.
  task automatic model(input bit d);
    exp_t e;
    int   p;
    k++;
    e = cur;
    e.stb = 1'b0;
    e.vld = 1'b0;
    if (d && !prev) begin
      e.stb    = 1'b1;
      cur.lost = 1'b0;
      if (!present) begin
        present = 1'b1;
        run     = 0;
      end else begin
        p = k - last_rise;
        cur.period = (p > 8191) ? CNT_W'(8191) : CNT_W'(p);
        e.vld = 1'b1;
        if (p >= N - TOL && p <= N + TOL && p < 8191) run++;
        else run = 0;
      end
      last_rise = k;
    end else if (present && (k - last_rise) == 2 * N) begin
      present  = 1'b0;
      run      = 0;
      cur.lost = 1'b1;
    end
    prev       = d;
    cur.locked = present && (run >= LOCK_CNT);
    e.locked   = cur.locked;
    e.lost     = cur.lost;
    e.period   = cur.period;
    q.push_back(e);
  endtask

  task automatic step(input bit d);
    exp_t e;
    bus.div_in = d;
    @(posedge clk);
    model(d);
    #1;
    e = q.pop_front();
    chk_all(e);
  endtask

  task automatic per(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  task automatic do_reset();
    exp_t z;
    z = '0;
    bus.div_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all(z);
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    k         = 0;
    last_rise = 0;
    run       = 0;
    present   = 1'b0;
    prev      = 1'b0;
    cur       = '0;
    q.delete();
    repeat (LAT) q.push_back(z);
  endtask

  initial begin
    int hi, lo, sel;
    rst_n = 1'b1;
    bus.div_in = 1'b0;
    #2;
    do_reset();

    // Nominal clock: lock on the 5th rise.
    repeat (4) per(256, 256);
    chk("not_locked_4", CNT_W'(bus.locked), CNT_W'(0));
    per(256, 256);
    chk("locked_5", CNT_W'(bus.locked), CNT_W'(1));
    chk("period_512", bus.period, CNT_W'(512));

    // One long period while locked, then relock.
    per(256, 264);
    per(256, 256);
    chk("period_520", bus.period, CNT_W'(520));
    chk("unlock_520", CNT_W'(bus.locked), CNT_W'(0));
    repeat (4) per(256, 256);
    chk("relock", CNT_W'(bus.locked), CNT_W'(1));

    // Clock stops: timeout, then restart.
    repeat (1100) step(1'b0);
    chk("lost_set", CNT_W'(bus.lost), CNT_W'(1));
    chk("lost_unlock", CNT_W'(bus.locked), CNT_W'(0));
    per(256, 256);
    chk("lost_clear", CNT_W'(bus.lost), CNT_W'(0));

    // Tolerance boundaries.
    per(256, 252); per(256, 260); per(256, 252);
    per(256, 251); per(256, 260); per(256, 252);
    per(256, 260); per(256, 261); per(256, 256);
    chk("bad_517_unlocked", CNT_W'(bus.locked), CNT_W'(0));
    chk("period_517", bus.period, CNT_W'(517));
    repeat (4) per(256, 256);
    chk("relock_boundary", CNT_W'(bus.locked), CNT_W'(1));

    // Reset mid-period while locked, then relock from scratch.
    repeat (100) step(1'b1);
    do_reset();
    repeat (4) per(256, 256);
    chk("reset_not_locked", CNT_W'(bus.locked), CNT_W'(0));
    per(256, 256);
    chk("reset_relock", CNT_W'(bus.locked), CNT_W'(1));

    // Period of exactly 2N: edge beats timeout.
    per(512, 512);
    repeat (10) step(1'b1);
    chk("period_1024", bus.period, CNT_W'(1024));
    chk("no_lost_1024", CNT_W'(bus.lost), CNT_W'(0));
    chk("meas_1024", CNT_W'(bus.locked), CNT_W'(0));
    repeat (246) step(1'b1);
    repeat (256) step(1'b0);

    // Randomized periods, mostly near N, some far off or long enough to time out.
    repeat (30) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7) begin
        hi = int'($urandom_range(200, 300));
        lo = N + int'($urandom_range(0, 12)) - 6 - hi;
      end else begin
        hi = int'($urandom_range(2, 500));
        lo = int'($urandom_range(2, 700));
      end
      per(hi, lo);
    end
    repeat (8) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
